ori_cpu_status: RTL and testbench
=================================

# ori_cpu_status

Full 8080-style status-word decoder and bus-cycle tracker for the Orion CPU interface. It supersedes the single-bit M1 latch. It captures the complete status byte at SYNC, tracks the machine-cycle phase (T1/T2/TW/T3) and counts wait states. It also produces qualified memory/IO read/write strobes for the address decoder and the peripheral blocks. It sits between the CPU pin interface and the system bus logic, all in the `clk_i` domain, with `cpu_f1_i`/`cpu_f2_i` acting as phase enables.

## Interface
- `WAIT_W`, 4: width of the wait-state counter; the counter saturates at 2^WAIT_W-1.
- `RD_QUAL`, 1: when 1, read strobes are gated with `cpu_dbin_i`; when 0, they follow the latched status only.
- `M1_BIT`, 5: status bit index that defines the M1 (opcode fetch) flag.
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `cpu_f1_i`  in  1  one-clk enable pulse marking the phase-1 edge.
- `cpu_f2_i`  in  1  one-clk enable pulse marking the phase-2 edge.
- `cpu_sync_i`  in  1  CPU SYNC; high during T1.
- `cpu_dbin_i`  in  1  CPU data-bus-in (read) strobe.
- `cpu_wr_n_i`  in  1  CPU write strobe, active low.
- `cpu_ready_i`  in  1  READY; low inserts wait states.
- `cpu_data_i`  in  8  data bus; carries the status word during SYNC.
- `status_o`  out  8  latched status byte.
- `cpu_m1_o`, `cpu_inta_o`, `cpu_hlta_o`, `cpu_stack_o`  out  1 each  decoded status flags, qualified by the cycle being active.
- `mem_rd_o`, `mem_wr_o`, `io_rd_o`, `io_wr_o`  out  1 each  qualified bus strobes.
- `cyc_state_o`  out  2  0=IDLE, 1=T1, 2=T2/TW, 3=T3.
- `wait_o`  out  1  high while in TW.
- `wait_cnt_o`  out  WAIT_W  number of wait states in the current cycle.
- `stat_vld_o`  out  1  one-clk pulse when a new status byte is captured.

## Operation
- Status bit map: D0 INTA, D1 WO_n, D2 STACK, D3 HLTA, D4 OUT, D5 M1 (`M1_BIT`), D6 INP, D7 MEMR.
- Capture: `cpu_f1_i & cpu_sync_i` in IDLE or T3 loads `status_o <= cpu_data_i`, pulses `stat_vld_o`, clears `wait_cnt_o`, and enters T1.
- SYNC seen in T1, T2 or TW is ignored and causes no recapture.
- FSM advances only on `cpu_f1_i`:
  - T1 -> T2.
  - T2 -> T3 if `cpu_ready_i` was high at the last `cpu_f2_i`; otherwise T2 -> TW.
  - TW -> TW while READY is low, and `wait_cnt_o` increments (saturating) on each TW f1.
  - TW -> T3 once READY is high.
  - T3 -> T1 on SYNC; otherwise T3 -> IDLE.
- READY is sampled on `cpu_f2_i` into an internal register. READY sampled while outside T2/TW has no effect.
- Active = state != IDLE. The decoded flags equal the status bits AND active. `cpu_hlta_o` is the exception: it stays high in IDLE until the next capture, so the halt state remains visible.
- Strobes:
  - `mem_rd_o` = active & D7 & (dbin | !RD_QUAL).
  - `io_rd_o` = active & D6 & (dbin | !RD_QUAL).
  - `mem_wr_o` = active & !D1 & !D4 & !wr_n.
  - `io_wr_o` = active & D4 & !wr_n.
- The strobes are combinational from registered status and the live `cpu_dbin_i`/`cpu_wr_n_i`. The flags are registered.
- Legacy compatibility: `cpu_m1_o` drops on the first `cpu_f1_i` where `cpu_dbin_i` is low after T3, i.e. when the FSM leaves T3 to IDLE.

## Timing
- Reset, asynchronous, `rst_n_i`=0:
  - State IDLE.
  - `status_o`=0x00.
  - All flags and strobes 0.
  - `wait_cnt_o`=0.
  - `stat_vld_o`=0.
  - Internal READY register = 1.
- Reset mid-cycle aborts the cycle immediately. The next cycle must restart from a SYNC.
- `status_o`, `cyc_state_o`=1 and `stat_vld_o` are visible 1 clk after the capturing f1 edge.
- Back-to-back cycles: SYNC at the T3 f1 goes directly to T1 with no IDLE gap. `stat_vld_o` pulses again and `wait_cnt_o` is cleared in the same clk.
- `wait_cnt_o` holds its value through T3 and IDLE until the next capture.
- When f1 and f2 are high in the same clk, f1 transitions use the READY value registered before that clk.

## Test plan
- Opcode fetch: SYNC with data 0xA2, READY high.
  - `stat_vld_o` pulses and `status_o`=0xA2.
  - `cpu_m1_o`=1 and `mem_rd_o` follows dbin.
  - States go 1 -> 2 -> 3 -> 0, and `wait_cnt_o`=0.
- Wait states: memory read 0x82 with READY low for 3 f2 samples.
  - `wait_o` is high for 3 f1 periods and `wait_cnt_o`=3.
  - T3 follows after READY returns high.
  - With `WAIT_W`=2 and 5 waits, `wait_cnt_o` saturates at 3.
- Writes:
  - Status 0x00 with wr_n low in T3 gives `mem_wr_o`=1 and `io_wr_o`=0.
  - Status 0x10 with wr_n low gives `io_wr_o`=1 and `mem_wr_o`=0.
- Back-to-back and halt:
  - SYNC at the T3 f1 recaptures directly into T1.
  - Status 0x8A (HLTA) followed by IDLE keeps `cpu_hlta_o`=1, and `cpu_m1_o`=0 in IDLE.
- Reset mid-TW: assert `rst_n_i` low asynchronously between clk edges.
  - All outputs go to 0 immediately and the state is IDLE.
  - After release, a spurious f1 with SYNC low remains in IDLE.
- `RD_QUAL`=0: status 0x42 gives `io_rd_o`=1 from T1 through T3 independent of dbin.

Source files
------------

// File: rtl/ori_cpu_status.sv
`timescale 1ns/1ps
// ori_cpu_status
// ---------------------------------------------------------------------------
// 8080-style status-word decoder and bus-cycle tracker for the Orion CPU
// interface. The status byte is captured on the phase-1 enable while SYNC is
// high. After capture the block walks through T1 / T2 / TW / T3, counts wait
// states and produces qualified memory/IO read and write strobes.
//
// Parameters
//   WAIT_W   width of the wait-state counter (saturates at all ones)
//   RD_QUAL  1: read strobes are gated with cpu_dbin_i, 0: status only
//   M1_BIT   status bit index holding the M1 (opcode fetch) flag
//
// Ports
//   clk_i                system clock, rising edge
//   rst_n_i              asynchronous active-low reset
//   cpu_f1_i / cpu_f2_i  one-clk phase enables
//   cpu_sync_i           CPU SYNC (T1 marker)
//   cpu_dbin_i           CPU read strobe
//   cpu_wr_n_i           CPU write strobe, active low
//   cpu_ready_i          READY, low inserts wait states
//   cpu_data_i           data bus, carries the status word during SYNC
//   status_o             latched status byte
//   cpu_m1_o, cpu_inta_o, cpu_hlta_o, cpu_stack_o   registered decoded flags
//   mem_rd_o, mem_wr_o, io_rd_o, io_wr_o            combinational bus strobes
//   cyc_state_o          0 IDLE, 1 T1, 2 T2/TW, 3 T3
//   wait_o               high while in TW
//   wait_cnt_o           wait states in the current cycle
//   stat_vld_o           one-clk pulse when a status byte is captured
// ---------------------------------------------------------------------------
module ori_cpu_status #(
    parameter int WAIT_W  = 4,
    parameter bit RD_QUAL = 1'b1,
    parameter int M1_BIT  = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_f1_i,
    input  logic              cpu_f2_i,
    input  logic              cpu_sync_i,
    input  logic              cpu_dbin_i,
    input  logic              cpu_wr_n_i,
    input  logic              cpu_ready_i,
    input  logic [7:0]        cpu_data_i,
    output logic [7:0]        status_o,
    output logic              cpu_m1_o,
    output logic              cpu_inta_o,
    output logic              cpu_hlta_o,
    output logic              cpu_stack_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic              io_rd_o,
    output logic              io_wr_o,
    output logic [1:0]        cyc_state_o,
    output logic              wait_o,
    output logic [WAIT_W-1:0] wait_cnt_o,
    output logic              stat_vld_o
);

    // Status bit positions
    localparam int B_INTA  = 0;
    localparam int B_WO_N  = 1;
    localparam int B_STACK = 2;
    localparam int B_HLTA  = 3;
    localparam int B_OUT   = 4;
    localparam int B_INP   = 6;
    localparam int B_MEMR  = 7;

    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        status_q, status_d;
    logic              ready_q, ready_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              stat_vld_q, stat_vld_d;
    logic              m1_q, m1_d;
    logic              inta_q, inta_d;
    logic              hlta_q, hlta_d;
    logic              stack_q, stack_d;

    logic              capture;
    logic              active_d;
    logic              active;
    logic              rd_en;

    // A new status word is only accepted between cycles (IDLE) or at the
    // T3 phase-1 edge, which gives back-to-back cycles without an IDLE gap.
    assign capture = cpu_f1_i & cpu_sync_i &
                     ((state_q == ST_IDLE) || (state_q == ST_T3));

    // ------------------------------------------------------------------
    // Next-state and flag logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        ready_d    = ready_q;
        wait_cnt_d = wait_cnt_q;
        stat_vld_d = 1'b0;

        // READY only matters while the cycle can still stretch.
        if (cpu_f2_i && ((state_q == ST_T2) || (state_q == ST_TW))) begin
            ready_d = cpu_ready_i;
        end

        if (capture) begin
            state_d    = ST_T1;
            status_d   = cpu_data_i;
            wait_cnt_d = '0;
            stat_vld_d = 1'b1;
        end else if (cpu_f1_i) begin
            // Transitions use ready_q, i.e. the value registered before
            // this clk, even if f2 is asserted in the same clk.
            case (state_q)
                ST_T1: state_d = ST_T2;
                ST_T2, ST_TW: begin
                    if (ready_q) begin
                        state_d = ST_T3;
                    end else begin
                        state_d = ST_TW;
                        // Each f1 that lands in TW is one wait state.
                        if (wait_cnt_q != WAIT_MAX) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end
                end
                ST_T3:   state_d = ST_IDLE;
                default: state_d = state_q;
            endcase
        end

        // Flags are registered from next-state values so they line up with
        // cyc_state_o and status_o.
        active_d = (state_d != ST_IDLE);
        m1_d     = status_d[M1_BIT] & active_d;
        inta_d   = status_d[B_INTA] & active_d;
        stack_d  = status_d[B_STACK] & active_d;
        // HLTA stays visible in IDLE until the next capture replaces it.
        hlta_d   = status_d[B_HLTA] & (active_d | hlta_q);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            status_q   <= 8'h00;
            ready_q    <= 1'b1;
            wait_cnt_q <= '0;
            stat_vld_q <= 1'b0;
            m1_q       <= 1'b0;
            inta_q     <= 1'b0;
            hlta_q     <= 1'b0;
            stack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            ready_q    <= ready_d;
            wait_cnt_q <= wait_cnt_d;
            stat_vld_q <= stat_vld_d;
            m1_q       <= m1_d;
            inta_q     <= inta_d;
            hlta_q     <= hlta_d;
            stack_q    <= stack_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus strobes: registered status combined with the live CPU strobes
    // ------------------------------------------------------------------
    assign active = (state_q != ST_IDLE);
    assign rd_en  = RD_QUAL ? cpu_dbin_i : 1'b1;

    assign mem_rd_o = active & status_q[B_MEMR] & rd_en;
    assign io_rd_o  = active & status_q[B_INP] & rd_en;
    assign mem_wr_o = active & ~status_q[B_WO_N] & ~status_q[B_OUT] & ~cpu_wr_n_i;
    assign io_wr_o  = active & status_q[B_OUT] & ~cpu_wr_n_i;

    // ------------------------------------------------------------------
    // Remaining outputs
    // ------------------------------------------------------------------
    always_comb begin
        cyc_state_o = 2'd0;
        case (state_q)
            ST_T1:        cyc_state_o = 2'd1;
            ST_T2, ST_TW: cyc_state_o = 2'd2;
            ST_T3:        cyc_state_o = 2'd3;
            default:      cyc_state_o = 2'd0;
        endcase
    end

    assign wait_o      = (state_q == ST_TW);
    assign status_o    = status_q;
    assign wait_cnt_o  = wait_cnt_q;
    assign stat_vld_o  = stat_vld_q;
    assign cpu_m1_o    = m1_q;
    assign cpu_inta_o  = inta_q;
    assign cpu_hlta_o  = hlta_q;
    assign cpu_stack_o = stack_q;

endmodule

// File: tb/tb_ori_cpu_status.sv
`timescale 1ns/1ps
// Testbench for ori_cpu_status. Two instances share the CPU-side stimulus:
// dut_a uses the default parameters, dut_b uses WAIT_W=2 and RD_QUAL=0 so
// counter saturation and unqualified reads are exercised on the same bus.
module tb_ori_cpu_status;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, f1, f2, sync, dbin, wr_n, ready;
    logic [7:0] data;

    logic [7:0] a_status, b_status;
    logic       a_m1, a_inta, a_hlta, a_stack, a_mem_rd, a_mem_wr, a_io_rd, a_io_wr;
    logic       b_m1, b_inta, b_hlta, b_stack, b_mem_rd, b_mem_wr, b_io_rd, b_io_wr;
    logic [1:0] a_cyc, b_cyc;
    logic       a_wait, b_wait, a_vld, b_vld;
    logic [3:0] a_cnt;
    logic [1:0] b_cnt;

    ori_cpu_status #(.WAIT_W(4), .RD_QUAL(1'b1), .M1_BIT(5)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .cpu_f1_i(f1), .cpu_f2_i(f2),
        .cpu_sync_i(sync), .cpu_dbin_i(dbin), .cpu_wr_n_i(wr_n),
        .cpu_ready_i(ready), .cpu_data_i(data), .status_o(a_status),
        .cpu_m1_o(a_m1), .cpu_inta_o(a_inta), .cpu_hlta_o(a_hlta),
        .cpu_stack_o(a_stack), .mem_rd_o(a_mem_rd), .mem_wr_o(a_mem_wr),
        .io_rd_o(a_io_rd), .io_wr_o(a_io_wr), .cyc_state_o(a_cyc),
        .wait_o(a_wait), .wait_cnt_o(a_cnt), .stat_vld_o(a_vld)
    );

    ori_cpu_status #(.WAIT_W(2), .RD_QUAL(1'b0), .M1_BIT(5)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .cpu_f1_i(f1), .cpu_f2_i(f2),
        .cpu_sync_i(sync), .cpu_dbin_i(dbin), .cpu_wr_n_i(wr_n),
        .cpu_ready_i(ready), .cpu_data_i(data), .status_o(b_status),
        .cpu_m1_o(b_m1), .cpu_inta_o(b_inta), .cpu_hlta_o(b_hlta),
        .cpu_stack_o(b_stack), .mem_rd_o(b_mem_rd), .mem_wr_o(b_mem_wr),
        .io_rd_o(b_io_rd), .io_wr_o(b_io_wr), .cyc_state_o(b_cyc),
        .wait_o(b_wait), .wait_cnt_o(b_cnt), .stat_vld_o(b_vld)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the bus cycle should look like
    logic [7:0] cur_st;     // last captured status byte
    int         cur_cnt;    // wait states seen in the current cycle
    logic       hlta_m;     // halt flag as seen from outside

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_f1();
        f1 = 1'b1;
        tick();
        f1 = 1'b0;
    endtask

    task automatic pulse_f2(input logic rdy);
        ready = rdy;
        f2    = 1'b1;
        tick();
        f2    = 1'b0;
        ready = 1'($urandom);
    endtask

    // Compare every output of both instances with the model for the given
    // bus phase, sweeping dbin/wr_n to exercise the combinational strobes.
    task automatic check_cycle(input string tag, input logic [1:0] exp_state,
                               input logic exp_wait);
        logic       act, d, w;
        logic [3:0] ea;
        logic [1:0] eb;
        act = (exp_state != 2'd0);
        ea  = (cur_cnt > 15) ? 4'd15 : 4'(cur_cnt);
        eb  = (cur_cnt > 3)  ? 2'd3  : 2'(cur_cnt);
        check({tag, "/state_a"}, 8'(a_cyc), 8'(exp_state));
        check({tag, "/state_b"}, 8'(b_cyc), 8'(exp_state));
        check({tag, "/wait_a"}, 8'(a_wait), 8'(exp_wait));
        check({tag, "/wait_b"}, 8'(b_wait), 8'(exp_wait));
        check({tag, "/cnt_a"}, 8'(a_cnt), 8'(ea));
        check({tag, "/cnt_b"}, 8'(b_cnt), 8'(eb));
        check({tag, "/status_a"}, a_status, cur_st);
        check({tag, "/status_b"}, b_status, cur_st);
        check({tag, "/m1"}, {6'd0, b_m1, a_m1}, {6'd0, {2{act & cur_st[5]}}});
        check({tag, "/inta"}, {6'd0, b_inta, a_inta}, {6'd0, {2{act & cur_st[0]}}});
        check({tag, "/stack"}, {6'd0, b_stack, a_stack}, {6'd0, {2{act & cur_st[2]}}});
        check({tag, "/hlta"}, {6'd0, b_hlta, a_hlta}, {6'd0, {2{hlta_m}}});
        for (int c = 0; c < 4; c++) begin
            d    = c[0];
            w    = c[1];
            dbin = d;
            wr_n = w;
            #1;
            check($sformatf("%s/rd_a d%0d", tag, d), {6'd0, a_io_rd, a_mem_rd},
                  {6'd0, act & cur_st[6] & d, act & cur_st[7] & d});
            check($sformatf("%s/rd_b d%0d", tag, d), {6'd0, b_io_rd, b_mem_rd},
                  {6'd0, act & cur_st[6], act & cur_st[7]});
            check($sformatf("%s/wr_a w%0d", tag, w), {6'd0, a_io_wr, a_mem_wr},
                  {6'd0, act & cur_st[4] & !w, act & !cur_st[1] & !cur_st[4] & !w});
            check($sformatf("%s/wr_b w%0d", tag, w), {6'd0, b_io_wr, b_mem_wr},
                  {6'd0, act & cur_st[4] & !w, act & !cur_st[1] & !cur_st[4] & !w});
        end
        dbin = 1'($urandom);
        wr_n = 1'($urandom);
    endtask

    // SYNC at an f1 edge from IDLE or T3 starts a new cycle.
    task automatic capture(input logic [7:0] st);
        sync = 1'b1;
        data = st;
        pulse_f1();
        sync    = 1'b0;
        data    = 8'($urandom);
        cur_st  = st;
        cur_cnt = 0;
        hlta_m  = st[3];
        check("cap/vld", {6'd0, b_vld, a_vld}, 8'h03);
        check_cycle("T1", 2'd1, 1'b0);
        tick();
        check("cap/vld_drop", {6'd0, b_vld, a_vld}, 8'h00);
    endtask

    // From T1 through T2, nwait wait states, into T3.
    task automatic body(input int nwait);
        $display("cycle status=0x%02h waits=%0d", cur_st, nwait);
        pulse_f2(1'($urandom));          // READY in T1 must not matter
        tick();
        sync = 1'($urandom);             // SYNC in T1 must not recapture
        data = ~cur_st;
        pulse_f1();
        sync = 1'b0;
        check("T2/vld", {6'd0, b_vld, a_vld}, 8'h00);
        check_cycle("T2", 2'd2, 1'b0);
        for (int i = 0; i < nwait; i++) begin
            pulse_f2(1'b0);
            pulse_f1();
            cur_cnt++;
            check_cycle("TW", 2'd2, 1'b1);
        end
        pulse_f2(1'b1);
        pulse_f1();
        check_cycle("T3", 2'd3, 1'b0);
        pulse_f2(1'($urandom));          // READY in T3 must not matter
    endtask

    task automatic end_cycle();
        sync = 1'b0;
        pulse_f1();
        check_cycle("IDLE", 2'd0, 1'b0);
    endtask

    initial begin
        logic       b2b;
        logic [7:0] st;
        int         nw;

        rst_n = 1'b0; f1 = 1'b0; f2 = 1'b0; sync = 1'b0;
        dbin = 1'b1; wr_n = 1'b0; ready = 1'b1; data = 8'h00;
        cur_st = 8'h00; cur_cnt = 0; hlta_m = 1'b0;

        // Reset state
        tick();
        check("rst/vld", {6'd0, b_vld, a_vld}, 8'h00);
        check_cycle("RST", 2'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Opcode fetch
        capture(8'hA2); body(0); end_cycle();
        // Memory read with 3 and 5 wait states (instance b saturates at 3)
        capture(8'h82); body(3); end_cycle();
        capture(8'h82); body(5); end_cycle();
        // Memory write, then IO write back-to-back into a halt cycle
        capture(8'h00); body(0); end_cycle();
        capture(8'h10); body(1);
        capture(8'h8A); body(0); end_cycle();
        // IO read (unqualified on instance b)
        capture(8'h42); body(2); end_cycle();

        // f1 and f2 in the same clk: f1 must use READY registered earlier (1)
        capture(8'h82);
        pulse_f2(1'b0);
        pulse_f1();
        check_cycle("T2s", 2'd2, 1'b0);
        ready = 1'b0; f1 = 1'b1; f2 = 1'b1;
        tick();
        f1 = 1'b0; f2 = 1'b0;
        check_cycle("T3s", 2'd3, 1'b0);
        end_cycle();

        // Asynchronous reset in the middle of TW
        capture(8'hA2);
        pulse_f2(1'b1);
        pulse_f1();
        pulse_f2(1'b0);
        pulse_f1();
        cur_cnt = 1;
        check_cycle("TWr", 2'd2, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        cur_st = 8'h00; cur_cnt = 0; hlta_m = 1'b0;
        $display("reset asserted mid-TW");
        check("rstTW/vld", {6'd0, b_vld, a_vld}, 8'h00);
        check_cycle("RSTW", 2'd0, 1'b0);
        rst_n = 1'b1;
        sync  = 1'b0;
        pulse_f1();
        check_cycle("POSTRST", 2'd0, 1'b0);

        // Random cycles, optionally back-to-back
        b2b = 1'b0;
        for (int k = 0; k < 30; k++) begin
            st = 8'($urandom);
            nw = int'($urandom_range(0, 6));
            capture(st);
            body(nw);
            b2b = 1'($urandom);
            if (!b2b) end_cycle();
        end
        if (b2b) end_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
